// File: rtl/md_pkg.sv
// md_pkg: op codes, classification helpers and default latencies
// shared by md_ctrl, the decoder and the hazard unit (MD_CTRL_MADD_EN adds MADD family)
package md_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t OP_NOP   = 4'd0;
    localparam md_op_t OP_MULT  = 4'd1;
    localparam md_op_t OP_MULTU = 4'd2;
    localparam md_op_t OP_DIV   = 4'd3;
    localparam md_op_t OP_DIVU  = 4'd4;
    localparam md_op_t OP_MTHI  = 4'd5;
    localparam md_op_t OP_MTLO  = 4'd6;
    localparam md_op_t OP_MADD  = 4'd7;
    localparam md_op_t OP_MADDU = 4'd8;
    localparam md_op_t OP_MSUB  = 4'd9;
    localparam md_op_t OP_MSUBU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_t;

    function automatic logic is_mult(md_op_t op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_CTRL_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: request/status bundle between the EX stage and md_ctrl
// master drives the request, slave returns busy/hazard and HI/LO
interface md_if;
    import md_pkg::*;

    logic        start;
    logic        flush;
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, flush, op, a, b,
        input  busy, md_hazard, hi, lo
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, md_hazard, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {hi,lo} result for mult/div ops
// with MD_CTRL_MADD_EN it also accumulates into the current {hi,lo}
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_CTRL_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] res
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic        ovf;

    // low 64 bits of the extended products give exact signed/unsigned results
    always_comb begin
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {32'b0, a} * {32'b0, b};
    end

    // signed divide via magnitudes, then restore signs (truncate toward zero)
    always_comb begin
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        uq    = '0;
        ur    = '0;
        sq    = '0;
        sr    = '0;
        if (b != 32'd0) begin
            uq = a / b;
            ur = a % b;
            sq = mag_a / mag_b;
            sr = mag_a % mag_b;
        end
        if (a[31] ^ b[31]) sq = ~sq + 32'd1;
        if (a[31])         sr = ~sr + 32'd1;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end

    // result select; divide by zero and signed overflow are fixed values
    always_comb begin
        res = '0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else if (ovf)   res = {32'd0, 32'h8000_0000};
                else            res = {sr, sq};
            end
            OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {ur, uq};
            end
`ifdef MD_CTRL_MADD_EN
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
`endif
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div controller with HI/LO and busy/hazard
// optional MADD/MSUB family enabled by defining MD_CTRL_MADD_EN
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_t   state;
    md_state_t   state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [63:0] pending;
    logic [63:0] pend_n;
    logic [31:0] hi_q;
    logic [31:0] hi_n;
    logic [31:0] lo_q;
    logic [31:0] lo_n;
    logic [63:0] res;
    logic        accept;
    logic        md_class;

    md_arith u_arith (
        .op  (bus.op),
        .a   (bus.a),
        .b   (bus.b),
`ifdef MD_CTRL_MADD_EN
        .acc ({hi_q, lo_q}),
`endif
        .res (res)
    );

    assign md_class      = is_mult(bus.op) | is_div(bus.op);
    assign accept        = bus.start & ~bus.flush & (state == S_IDLE);
    assign bus.busy      = (state == S_BUSY);
    assign bus.md_hazard = bus.busy | (bus.start & ~bus.flush & md_class);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // state, counter, pending result and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pending <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pend_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
        end
    end

    // accept in IDLE, count down in BUSY, commit pending when cnt hits 1
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pending;
        hi_n    = hi_q;
        lo_n    = lo_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mult(bus.op)) begin
                        state_n = S_BUSY;
                        cnt_n   = CW'(MULT_CYCLES);
                        pend_n  = res;
                    end else if (is_div(bus.op)) begin
                        state_n = S_BUSY;
                        cnt_n   = CW'(DIV_CYCLES);
                        pend_n  = res;
                    end else if (bus.op == OP_MTHI) begin
                        hi_n = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_n = bus.a;
                    end
                end
            end
            S_BUSY: begin
                if (cnt == CW'(1)) begin
                    state_n    = S_IDLE;
                    cnt_n      = '0;
                    {hi_n, lo_n} = pending;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide controller with architectural HI/LO registers. It sits in the EX stage beside the ALU. It accepts one mult/div/move-to request per idle cycle and holds the result for a fixed, parameterised latency. It drives the busy status that the hazard unit uses to stall later mult/div/mfhi/mflo instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family), ≥1
- DIV_CYCLES, 10, busy cycles for DIV/DIVU, ≥1
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request valid this cycle (EX stage holds an MD instruction)
- flush  input  1  exception/cancel; a start in the same cycle is discarded
- op  input  4  md_pkg operation code
- a  input  32  rs operand
- b  input  32  rt operand
- busy  output  1  registered; high while an operation is in flight
- md_hazard  output  1  combinational: busy | (start & ~flush & op is mult/div class)
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU. Codes 11–15 are NOP.
- FSM states:
  - IDLE: an accepted MULT-class op loads cnt=MULT_CYCLES and enters BUSY. An accepted DIV-class op loads cnt=DIV_CYCLES and enters BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, pending→{hi,lo} and the FSM returns to IDLE.
- Accept condition: start & ~flush & state==IDLE.
- The 64-bit result is computed combinationally from a and b at accept and captured in a pending register. HI/LO change only at completion.
- MULT: signed 32×32→64. MULTU: unsigned. hi=[63:32], lo=[31:0].
- DIV: lo=quotient truncated toward zero, hi=remainder with the dividend's sign. DIVU: unsigned.
- Divide by zero: lo=32'hFFFF_FFFF, hi=a.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- MTHI/MTLO: accepted only in IDLE. They write hi or lo at the next edge and do not enter BUSY.
- Start while BUSY is a pipeline protocol error. It is ignored with no state change. The bench flags it.
- Flush while BUSY does not abort the operation; a committed operation always completes.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending=0. Reset mid-operation discards the operation.
- Accept at edge E0. busy=1 for exactly N cycles after E0, where N is the op's latency. hi/lo take the new value at edge E0+N; busy=0 in the same cycle.
- A new start is acceptable in the cycle busy falls (back-to-back with 0 gap).
- MTHI/MTLO: value visible one cycle after accept. busy stays 0.
- md_hazard is high in the accept cycle and all N busy cycles.

## Configuration
- MD_CTRL_MADD_EN defined:
  - Ops 7–10 are MULT class.
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product, with signed or unsigned product respectively.
  - MSUB/MSUBU: {hi,lo} ← {hi,lo} − product.
  - {hi,lo} is sampled at accept, and the accumulation is modulo 2^64.
- MD_CTRL_MADD_EN undefined: ops 7–10 decode as NOP. No accumulator adder is synthesised.

## Structure
- Package md_pkg holds:
  - the op code localparams and the md_op_t typedef
  - the classification functions is_mult(op) and is_div(op)
  - the default latency constants
- md_pkg is shared with the decoder and the hazard unit.
- Sub-module md_arith contains the combinational 64-bit result generation: mult, div, the special cases and the optional MADD adder.
- md_ctrl contains the FSM, the counter, the pending register and HI/LO.

## Test plan
- Reset released → hi=0, lo=0, busy=0. MULT a=32'hFFFF_FFFF, b=2 → busy for 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE.
- MULTU with the same operands → hi=1, lo=32'hFFFF_FFFE, with hi/lo unchanged until the 5th edge after accept.
- DIV a=−7 (32'hFFFF_FFF9), b=2 → busy 10 cycles, then lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU a=7, b=0 → lo=32'hFFFF_FFFF, hi=7. DIV 32'h8000_0000 / −1 → lo=32'h8000_0000, hi=0.
- Back-to-back and illegal starts:
  - MTHI 32'h1234 in the cycle busy falls after a DIV → accepted, hi=32'h1234 one cycle later.
  - Start during BUSY → ignored.
  - start+flush → no busy, hi/lo unchanged.
  - rst_n low mid-DIV → hi=lo=0 and busy=0 immediately.
- With MD_CTRL_MADD_EN: hi=0, lo=32'hFFFF_FFFF, then MADDU a=1, b=1 → hi=1, lo=0. Without the macro the same op gives no busy and no change.
